// File: rtl/wb_pkg.sv
// Shared types for the writeback arbiter: issue-source encoding and the ALU result queue entry.
// Entry fields are sized to the widest supported configuration (ADDR_W <= 8, DATA_W <= 64).
package wb_pkg;

    localparam int WB_ADDR_MAX = 8;
    localparam int WB_DATA_MAX = 64;

    typedef enum logic [2:0] {
        WB_IDLE,
        WB_MEM,
        WB_ALU,
        WB_FORCE,
        WB_ORDER
    } wb_src_e;

    typedef struct packed {
        logic [WB_ADDR_MAX-1:0] rd;
        logic [WB_DATA_MAX-1:0] data;
        logic                   link_valid;
        logic [WB_DATA_MAX-1:0] link_data;
    } wb_entry_t;

endpackage

// File: rtl/writeback_arbiter_if.sv
// Requester, register-bank write-port and hazard-query signals of the writeback arbiter.
// slave = arbiter side, master = requesters / bank / decode side.
interface writeback_arbiter_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic              alu_valid;
    logic              alu_ready;
    logic [ADDR_W-1:0] alu_rd;
    logic [DATA_W-1:0] alu_data;
    logic              alu_link_valid;
    logic [DATA_W-1:0] alu_link_data;

    logic              mem_valid;
    logic              mem_ready;
    logic [ADDR_W-1:0] mem_rd;
    logic [DATA_W-1:0] mem_data;

    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              link_en;
    logic [DATA_W-1:0] link_data;

    logic [ADDR_W-1:0] query_addr;
    logic              hazard;

    modport slave (
        input  alu_valid, alu_rd, alu_data, alu_link_valid, alu_link_data,
        input  mem_valid, mem_rd, mem_data, query_addr,
        output alu_ready, mem_ready, wr_en, wr_addr, wr_data, link_en, link_data, hazard
    );

    modport master (
        output alu_valid, alu_rd, alu_data, alu_link_valid, alu_link_data,
        output mem_valid, mem_rd, mem_data, query_addr,
        input  alu_ready, mem_ready, wr_en, wr_addr, wr_data, link_en, link_data, hazard
    );
endinterface

// File: rtl/wb_result_fifo.sv
// ALU result queue: circular storage with wrapping pointers, occupancy count and
// per-entry destination compares against two addresses (only live entries can hit).
module wb_result_fifo
    import wb_pkg::*;
#(
    parameter int  ADDR_W     = 5,
    parameter int  FIFO_DEPTH = 2,
    localparam int PTR_W      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1,
    localparam int CNT_W      = PTR_W + 1
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  push,
    input  wb_entry_t             push_entry,
    input  logic                  pop,
    output wb_entry_t             head_entry,
    output logic [CNT_W-1:0]      count,
    input  logic [ADDR_W-1:0]     cmp_a_addr,
    output logic [FIFO_DEPTH-1:0] cmp_a_hit,
    input  logic [ADDR_W-1:0]     cmp_b_addr,
    output logic [FIFO_DEPTH-1:0] cmp_b_hit
);

    wb_entry_t             entries_q [FIFO_DEPTH];
    wb_entry_t             entries_d [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic [FIFO_DEPTH-1:0] live;

    always_comb begin
        entries_d = entries_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        if (push) begin
            entries_d[wr_ptr_q] = push_entry;
            wr_ptr_d            = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Storage is qualified by count, so it needs no reset.
    always_ff @(posedge clock) begin
        entries_q <= entries_d;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Slot i is live when its distance from the read pointer is below the occupancy.
    always_comb begin
        live      = '0;
        cmp_a_hit = '0;
        cmp_b_hit = '0;
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            live[i]      = ({1'b0, PTR_W'(i) - rd_ptr_q} < count_q);
            cmp_a_hit[i] = live[i] && (entries_q[i].rd == WB_ADDR_MAX'(cmp_a_addr));
            cmp_b_hit[i] = live[i] && (entries_q[i].rd == WB_ADDR_MAX'(cmp_b_addr));
        end
    end

    assign head_entry = entries_q[rd_ptr_q];
    assign count      = count_q;

endmodule

// File: rtl/writeback_arbiter.sv
// Arbitrates the single register-bank write port between queued ALU results and loads.
// Optional link-register path enabled by defining WB_ARB_LINK_EN.
module writeback_arbiter
    import wb_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 5,
    parameter int FIFO_DEPTH = 2,
    parameter int MAX_DEFER  = 3
) (
    input  logic               clock,
    input  logic               reset_n,
    writeback_arbiter_if.slave bus
);

    localparam int PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W   = PTR_W + 1;
    localparam int DEFER_W = (MAX_DEFER > 0) ? $clog2(MAX_DEFER + 1) : 1;
    localparam logic [DEFER_W-1:0] DEFER_MAX = DEFER_W'(MAX_DEFER);
    localparam logic [CNT_W-1:0]   DEPTH_C   = CNT_W'(FIFO_DEPTH);

    wb_entry_t             push_entry;
    wb_entry_t             head_entry;
    logic [CNT_W-1:0]      count;
    logic [FIFO_DEPTH-1:0] mem_hit;
    logic [FIFO_DEPTH-1:0] query_hit;
    logic                  push, pop, non_empty;
    wb_src_e               src;
    logic                  unused_head;

    logic [DEFER_W-1:0]    defer_q, defer_d;
    logic                  wr_en_q, wr_en_d;
    logic [ADDR_W-1:0]     wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0]     wr_data_q, wr_data_d;

    assign non_empty     = (count != '0);
    assign bus.alu_ready = (count < DEPTH_C);
    assign push          = bus.alu_valid && bus.alu_ready;
    assign unused_head   = ^head_entry;

    always_comb begin
        push_entry      = '0;
        push_entry.rd   = WB_ADDR_MAX'(bus.alu_rd);
        push_entry.data = WB_DATA_MAX'(bus.alu_data);
`ifdef WB_ARB_LINK_EN
        push_entry.link_valid = bus.alu_link_valid;
        push_entry.link_data  = WB_DATA_MAX'(bus.alu_link_data);
`endif
    end

    wb_result_fifo #(
        .ADDR_W     (ADDR_W),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock      (clock),
        .reset_n    (reset_n),
        .push       (push),
        .push_entry (push_entry),
        .pop        (pop),
        .head_entry (head_entry),
        .count      (count),
        .cmp_a_addr (bus.mem_rd),
        .cmp_a_hit  (mem_hit),
        .cmp_b_addr (bus.query_addr),
        .cmp_b_hit  (query_hit)
    );

    // A load to a register with an older queued write must wait so the bank sees them in order.
    always_comb begin
        src = WB_IDLE;
        if (non_empty && (defer_q == DEFER_MAX)) begin
            src = WB_FORCE;
        end else if (bus.mem_valid && (|mem_hit)) begin
            src = WB_ORDER;
        end else if (bus.mem_valid) begin
            src = WB_MEM;
        end else if (non_empty) begin
            src = WB_ALU;
        end
    end

    assign pop           = (src == WB_FORCE) || (src == WB_ORDER) || (src == WB_ALU);
    assign bus.mem_ready = (src == WB_MEM);

    always_comb begin
        defer_d   = defer_q;
        wr_en_d   = (src != WB_IDLE);
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        if (pop) begin
            defer_d = '0;
        end else if ((src == WB_MEM) && non_empty && (defer_q != DEFER_MAX)) begin
            defer_d = defer_q + 1'b1;
        end
        if (src == WB_MEM) begin
            wr_addr_d = bus.mem_rd;
            wr_data_d = bus.mem_data;
        end else if (pop) begin
            wr_addr_d = head_entry.rd[ADDR_W-1:0];
            wr_data_d = head_entry.data[DATA_W-1:0];
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            defer_q   <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            defer_q   <= defer_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end

    assign bus.wr_en   = wr_en_q;
    assign bus.wr_addr = wr_addr_q;
    assign bus.wr_data = wr_data_q;

`ifdef WB_ARB_LINK_EN
    logic              link_en_q, link_en_d;
    logic [DATA_W-1:0] link_data_q, link_data_d;

    always_comb begin
        link_en_d   = pop && head_entry.link_valid;
        link_data_d = link_data_q;
        if (link_en_d) begin
            link_data_d = head_entry.link_data[DATA_W-1:0];
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            link_en_q   <= 1'b0;
            link_data_q <= '0;
        end else begin
            link_en_q   <= link_en_d;
            link_data_q <= link_data_d;
        end
    end

    assign bus.link_en   = link_en_q;
    assign bus.link_data = link_data_q;
`else
    logic unused_link;
    assign unused_link   = ^{bus.alu_link_valid, bus.alu_link_data};
    assign bus.link_en   = 1'b0;
    assign bus.link_data = '0;
`endif

    // A decode read must stall on any queued write and on the write landing this cycle.
    assign bus.hazard = (|query_hit) || (wr_en_q && (wr_addr_q == bus.query_addr));

endmodule

// File: tb/tb_writeback_arbiter.sv
// Bench for writeback_arbiter: table of single-load vectors plus hand-written
// multi-cycle sequences, with every bank write checked against an expected-write queue.
module tb_writeback_arbiter;

    localparam int DATA_W     = 32;
    localparam int ADDR_W     = 5;
    localparam int FIFO_DEPTH = 2;
    localparam int MAX_DEFER  = 3;
`ifdef WB_ARB_LINK_EN
    localparam logic LINK_ON = 1'b1;
`else
    localparam logic LINK_ON = 1'b0;
`endif

    logic clock   = 1'b0;
    logic reset_n = 1'b0;

    writeback_arbiter_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    writeback_arbiter #(
        .DATA_W     (DATA_W),
        .ADDR_W     (ADDR_W),
        .FIFO_DEPTH (FIFO_DEPTH),
        .MAX_DEFER  (MAX_DEFER)
    ) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clock = ~clock;

    int n_vec = 0;
    int n_bad = 0;

    typedef struct {
        logic [4:0]  addr;
        logic [31:0] data;
        logic        link;
        logic [31:0] ldata;
    } wr_t;
    wr_t sb[$];

    typedef struct {
        logic        mv;
        logic [4:0]  mrd;
        logic [31:0] mdata;
        logic [4:0]  qa;
        logic        exp_mready;
        logic        exp_wen;
        logic [4:0]  exp_waddr;
        logic [31:0] exp_wdata;
        logic        exp_haz;
    } vec_t;
    vec_t vt[5];

    function automatic void chk1(string name, logic act, logic exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0b, want %0b", name, act, exp);
        end
    endfunction

    function automatic void chk32(string name, logic [31:0] act, logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endfunction

    function automatic void exp_wr(logic [4:0] a, logic [31:0] d, logic l, logic [31:0] ld);
        sb.push_back('{a, d, l, ld});
    endfunction

    // Every bank write must match the oldest outstanding expectation.
    always @(negedge clock) begin
        if (reset_n && (bus.wr_en !== 1'b0)) begin
            if (sb.size() == 0) begin
                n_vec++;
                n_bad++;
                $display("FAIL sb_unexpected_write: got addr %0h data %0h, want no write",
                         bus.wr_addr, bus.wr_data);
            end else begin
                wr_t e;
                e = sb.pop_front();
                chk32("sb_wr_addr", 32'(bus.wr_addr), 32'(e.addr));
                chk32("sb_wr_data", bus.wr_data, e.data);
                chk1("sb_link_en", bus.link_en, e.link);
                if (e.link) chk32("sb_link_data", bus.link_data, e.ldata);
                if (!LINK_ON) chk32("sb_link_data_tied", bus.link_data, 32'd0);
            end
        end
    end

    task automatic idle_inputs();
        bus.alu_valid      = 1'b0;
        bus.alu_rd         = '0;
        bus.alu_data       = '0;
        bus.alu_link_valid = 1'b0;
        bus.alu_link_data  = '0;
        bus.mem_valid      = 1'b0;
        bus.mem_rd         = '0;
        bus.mem_data       = '0;
        bus.query_addr     = '0;
    endtask

    task automatic next_cycle();
        @(posedge clock);
        #1;
    endtask

    initial begin
        int   ai;
        int   nl;
        logic acc_a;
        logic acc_m;

        vt[0] = '{1'b1, 5'd7,  32'hDEADBEEF, 5'd7,  1'b1, 1'b1, 5'd7,  32'hDEADBEEF, 1'b1};
        vt[1] = '{1'b1, 5'd0,  32'h00000000, 5'd1,  1'b1, 1'b1, 5'd0,  32'h00000000, 1'b0};
        vt[2] = '{1'b1, 5'd31, 32'hFFFFFFFF, 5'd31, 1'b1, 1'b1, 5'd31, 32'hFFFFFFFF, 1'b1};
        vt[3] = '{1'b0, 5'd12, 32'h00001234, 5'd31, 1'b0, 1'b0, 5'd31, 32'hFFFFFFFF, 1'b0};
        vt[4] = '{1'b1, 5'd12, 32'hA5A5A5A5, 5'd12, 1'b1, 1'b1, 5'd12, 32'hA5A5A5A5, 1'b1};

        idle_inputs();
        reset_n = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        chk1("rst_wr_en", bus.wr_en, 1'b0);
        chk1("rst_link_en", bus.link_en, 1'b0);
        chk32("rst_wr_addr", 32'(bus.wr_addr), 32'd0);
        chk32("rst_wr_data", bus.wr_data, 32'd0);
        chk32("rst_link_data", bus.link_data, 32'd0);
        reset_n = 1'b1;
        bus.mem_valid = 1'b1;
        bus.mem_rd    = 5'd3;
        @(negedge clock);
        chk1("post_rst_alu_ready", bus.alu_ready, 1'b1);
        chk1("post_rst_hazard", bus.hazard, 1'b0);
        chk1("post_rst_mem_ready", bus.mem_ready, 1'b1);
        exp_wr(5'd3, 32'd0, 1'b0, 32'd0);
        next_cycle();
        idle_inputs();
        next_cycle();

        // Single loads through an empty queue: decision cycle, then write cycle.
        for (int v = 0; v < 5; v++) begin
            bus.mem_valid  = vt[v].mv;
            bus.mem_rd     = vt[v].mrd;
            bus.mem_data   = vt[v].mdata;
            bus.query_addr = vt[v].qa;
            @(negedge clock);
            chk1("vec_mem_ready", bus.mem_ready, vt[v].exp_mready);
            chk1("vec_hazard_pre", bus.hazard, 1'b0);
            if (vt[v].exp_wen) exp_wr(vt[v].exp_waddr, vt[v].exp_wdata, 1'b0, 32'd0);
            next_cycle();
            bus.mem_valid = 1'b0;
            @(negedge clock);
            chk1("vec_wr_en", bus.wr_en, vt[v].exp_wen);
            chk32("vec_wr_addr", 32'(bus.wr_addr), 32'(vt[v].exp_waddr));
            chk32("vec_wr_data", bus.wr_data, vt[v].exp_wdata);
            chk1("vec_hazard_pending", bus.hazard, vt[v].exp_haz);
            next_cycle();
        end
        idle_inputs();

        // ALU fill against a continuous load stream: FORCE after 3 deferrals, order 1,2,3.
        exp_wr(5'd9, 32'h9000, 1'b0, 32'd0);
        exp_wr(5'd9, 32'h9001, 1'b0, 32'd0);
        exp_wr(5'd9, 32'h9002, 1'b0, 32'd0);
        exp_wr(5'd9, 32'h9003, 1'b0, 32'd0);
        exp_wr(5'd1, 32'hA001, 1'b0, 32'd0);
        exp_wr(5'd9, 32'h9004, 1'b0, 32'd0);
        exp_wr(5'd9, 32'h9005, 1'b0, 32'd0);
        exp_wr(5'd9, 32'h9006, 1'b0, 32'd0);
        exp_wr(5'd2, 32'hA002, 1'b0, 32'd0);
        exp_wr(5'd3, 32'hA003, 1'b0, 32'd0);
        ai = 0;
        nl = 0;
        for (int c = 0; c < 12; c++) begin
            bus.mem_valid = (c < 8);
            bus.mem_rd    = 5'd9;
            bus.mem_data  = 32'h9000 + 32'(nl);
            bus.alu_valid = (ai < 3);
            bus.alu_rd    = 5'(ai + 1);
            bus.alu_data  = 32'hA000 + 32'(ai + 1);
            @(negedge clock);
            if (c == 2) chk1("fill_alu_ready_full", bus.alu_ready, 1'b0);
            if (c == 3) chk1("fill_mem_ready_defer", bus.mem_ready, 1'b1);
            if (c == 4) chk1("fill_force_mem_ready", bus.mem_ready, 1'b0);
            if (c == 5) chk1("fill_alu_ready_freed", bus.alu_ready, 1'b1);
            acc_a = bus.alu_valid && bus.alu_ready;
            acc_m = bus.mem_valid && bus.mem_ready;
            next_cycle();
            if (acc_a) ai++;
            if (acc_m) nl++;
        end
        idle_inputs();
        chk32("fill_drained", 32'(sb.size()), 32'd0);

        // Load to a register with a queued ALU write waits behind it.
        exp_wr(5'd5, 32'h11, 1'b0, 32'd0);
        exp_wr(5'd5, 32'h22, 1'b0, 32'd0);
        bus.alu_valid = 1'b1;
        bus.alu_rd    = 5'd5;
        bus.alu_data  = 32'h11;
        @(negedge clock);
        chk1("order_alu_ready", bus.alu_ready, 1'b1);
        next_cycle();
        bus.alu_valid  = 1'b0;
        bus.mem_valid  = 1'b1;
        bus.mem_rd     = 5'd5;
        bus.mem_data   = 32'h22;
        bus.query_addr = 5'd5;
        @(negedge clock);
        chk1("order_mem_ready_blocked", bus.mem_ready, 1'b0);
        chk1("order_hazard_queued", bus.hazard, 1'b1);
        next_cycle();
        @(negedge clock);
        chk1("order_mem_ready_after", bus.mem_ready, 1'b1);
        chk1("order_hazard_pending", bus.hazard, 1'b1);
        next_cycle();
        bus.mem_valid  = 1'b0;
        bus.query_addr = 5'd6;
        @(negedge clock);
        chk1("order_hazard_other", bus.hazard, 1'b0);
        next_cycle();
        idle_inputs();
        next_cycle();

        // Link write, then a second entry accepted while the first issues.
        exp_wr(5'd14, 32'hCAFE, LINK_ON, 32'h100);
        exp_wr(5'd15, 32'hBEEF, 1'b0, 32'd0);
        bus.alu_valid      = 1'b1;
        bus.alu_rd         = 5'd14;
        bus.alu_data       = 32'hCAFE;
        bus.alu_link_valid = 1'b1;
        bus.alu_link_data  = 32'h100;
        next_cycle();
        bus.alu_rd         = 5'd15;
        bus.alu_data       = 32'hBEEF;
        bus.alu_link_valid = 1'b0;
        bus.alu_link_data  = 32'h200;
        @(negedge clock);
        chk1("link_alu_ready_one", bus.alu_ready, 1'b1);
        next_cycle();
        idle_inputs();
        @(negedge clock);
        chk1("link_enq_deq_ready", bus.alu_ready, 1'b1);
        chk1("link_en_direct", bus.link_en, LINK_ON);
        next_cycle();
        @(negedge clock);
        chk1("link_en_second", bus.link_en, 1'b0);
        next_cycle();
        next_cycle();

        // Reset pulsed with two ALU entries queued behind loads.
        exp_wr(5'd9, 32'h77, 1'b0, 32'd0);
        exp_wr(5'd9, 32'h78, 1'b0, 32'd0);
        bus.alu_valid = 1'b1;
        bus.alu_rd    = 5'd20;
        bus.alu_data  = 32'h1;
        bus.mem_valid = 1'b1;
        bus.mem_rd    = 5'd9;
        bus.mem_data  = 32'h77;
        next_cycle();
        bus.alu_rd    = 5'd21;
        bus.alu_data  = 32'h2;
        bus.mem_data  = 32'h78;
        next_cycle();
        bus.alu_valid  = 1'b0;
        bus.mem_data   = 32'h79;
        bus.query_addr = 5'd20;
        @(negedge clock);
        chk1("rstmid_hazard_before", bus.hazard, 1'b1);
        #2;
        reset_n = 1'b0;
        bus.mem_valid = 1'b0;
        #1;
        chk1("rstmid_wr_en", bus.wr_en, 1'b0);
        chk32("rstmid_wr_addr", 32'(bus.wr_addr), 32'd0);
        chk1("rstmid_alu_ready", bus.alu_ready, 1'b1);
        chk1("rstmid_hazard", bus.hazard, 1'b0);
        @(posedge clock);
        #2;
        reset_n = 1'b1;
        bus.query_addr = 5'd21;
        repeat (6) begin
            @(negedge clock);
            chk1("rstmid_no_write", bus.wr_en, 1'b0);
            chk1("rstmid_hazard_after", bus.hazard, 1'b0);
            chk1("rstmid_alu_ready_after", bus.alu_ready, 1'b1);
            next_cycle();
        end

        chk32("sb_all_writes_seen", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/writeback_arbiter.md
WRITEBACK_ARBITER -- requirements
Module: writeback_arbiter

Interface
REQ-001 SHALL have parameter DATA_W, default 32, register data width.
REQ-002 SHALL have parameter ADDR_W, default 5, register address width.
REQ-003 SHALL have parameter FIFO_DEPTH, default 2, ALU result queue entries (power of two, >=2).
REQ-004 SHALL have parameter MAX_DEFER, default 3, max consecutive cycles a queued ALU result may lose to the memory requester.
REQ-005 SHALL have one clock and an asynchronous active-low reset:
- clock  in  1  sole clock, rising edge.
- reset_n  in  1  asynchronous, active-low.
REQ-006 SHALL have the ALU requester ports:
- alu_valid  in  1  ALU result offered.
- alu_ready  out  1  queue can accept.
- alu_rd  in  ADDR_W  destination.
- alu_data  in  DATA_W  result.
- alu_link_valid  in  1  entry also updates link register.
- alu_link_data  in  DATA_W  new link value.
REQ-007 SHALL have the memory (load) requester ports:
- mem_valid  in  1  load data offered.
- mem_ready  out  1  load accepted this cycle.
- mem_rd  in  ADDR_W  destination.
- mem_data  in  DATA_W  load data.
REQ-008 SHALL have the register bank write-port outputs:
- wr_en  out  1  bank write enable.
- wr_addr  out  ADDR_W  destination.
- wr_data  out  DATA_W  value.
- link_en  out  1  link register write.
- link_data  out  DATA_W  link value.
REQ-009 SHALL have the hazard query ports:
- query_addr  in  ADDR_W  decode source address.
- hazard  out  1  queued write pending to query_addr.

Function
REQ-010 Transfer SHALL occur on a rising edge with valid&ready high; alu_ready = (count < FIFO_DEPTH), from registered count only, no same-cycle pass-through.
REQ-011 Accepted ALU entries {rd,data,link_valid,link_data} SHALL be written to the bank in acceptance order.
REQ-012 Issue decision per cycle, in priority order:
- FORCE: defer_cnt == MAX_DEFER and queue non-empty -> issue head, mem_ready=0.
- ORDER: mem_valid and any valid queue entry has rd == mem_rd -> issue head, mem_ready=0.
- MEM: mem_valid -> issue load, mem_ready=1.
- ALU: queue non-empty -> issue head.
- IDLE: wr_en=0.
REQ-013 defer_cnt SHALL increment when the queue is non-empty and MEM wins, clear when the head issues, and saturate at MAX_DEFER.
REQ-014 wr_en/wr_addr/wr_data/link_en/link_data SHALL be registered: the issue decided in cycle N appears in cycle N+1 for exactly one cycle.
REQ-015 Minimum latency SHALL be 1 cycle for a load and 2 cycles for an ALU result (accept edge to wr_en high).
REQ-016 Dequeue and enqueue on the same edge SHALL both take effect; count unchanged.
REQ-017 Pointers SHALL wrap modulo FIFO_DEPTH; count SHALL be 0..FIFO_DEPTH.
REQ-018 link_en SHALL be high only when an issued ALU entry has link_valid=1; loads never assert link_en.
REQ-019 hazard SHALL be combinational: 1 iff a valid queue entry or the registered pending write (wr_en) targets query_addr.
REQ-020 With wr_en=0, wr_addr/wr_data/link_data SHALL hold their previous values.

Reset
REQ-021 reset_n low SHALL immediately clear count, pointers and defer_cnt, and force wr_en=0, link_en=0, wr_addr=0, wr_data=0, link_data=0; queued entries are discarded.
REQ-022 After reset: alu_ready=1, hazard=0, mem_ready follows REQ-012 with an empty queue.

Configuration
REQ-023 Macro WB_ARB_LINK_EN defined: link path per REQ-018. Undefined: link storage omitted, link_en and link_data tied 0, alu_link_valid/alu_link_data ignored; ports remain.

Structure
REQ-024 Shared package wb_pkg SHALL hold the issue-source enum (WB_IDLE, WB_MEM, WB_ALU, WB_FORCE, WB_ORDER) and the queue-entry struct type.
REQ-025 Queue SHALL be sub-module wb_result_fifo (storage, pointers, count, per-entry address compare outputs).

Verification
REQ-026 Single load: mem_valid, rd=7, data=0xDEADBEEF -> mem_ready=1; next cycle wr_en=1, wr_addr=7, wr_data=0xDEADBEEF.
REQ-027 ALU fill: 3 back-to-back ALU results (rd=1,2,3) while mem_valid held high with rd=9 -> alu_ready=0 on third; FORCE issues rd=1 after 3 deferred cycles; writes in order 1,2,3.
REQ-028 ORDER: queue holds rd=5 (0x11); mem offers rd=5 (0x22) -> mem_ready=0; bank sees 0x11 then 0x22.
REQ-029 Link: ALU rd=14, link_valid=1, link_data=0x100 -> link_en=1, link_data=0x100 same cycle as the write; with WB_ARB_LINK_EN undefined, link_en stays 0.
REQ-030 Reset mid-operation: 2 entries queued, reset_n pulsed low between edges -> wr_en=0 immediately; no queued write appears after release; alu_ready=1.
